instr2cache_bridge: RTL

Parametrised, pipelined converter between the core instruction-fetch port and the tile I$. It supports up to MAX_OUTSTANDING in-flight fetches and narrows a wide I$ response word to the core fetch width, selecting the lane by address offset. Requests and grants pass through combinationally, gated by a credit counter. Responses are registered toward the core. It sits in the tile between the core instruction port and the I$ request/response ports.

---
 rtl/magia_tile_pkg.sv | 50 +++++
 rtl/instr2cache_offs_fifo.sv | 97 +++++++++
 rtl/instr2cache_bridge.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/magia_tile_pkg.sv
// Shared tile-level definitions for the instruction-fetch path.
// Holds the default widths of the core fetch port and the I$ port,
// the request/response bundles built from those widths, and a helper
// that sizes the lane-offset field used by the fetch bridge.
package magia_tile_pkg;

    localparam int INSTR_ADDR_W           = 32;
    localparam int INSTR_DATA_W           = 32;
    localparam int ICACHE_DATA_W          = 128;
    localparam int ICACHE_MAX_OUTSTANDING = 2;

    // Core fetch port, request side
    typedef struct packed {
        logic                    req;
        logic [INSTR_ADDR_W-1:0] addr;
    } core_instr_req_t;

    // Core fetch port, response side (core-width data)
    typedef struct packed {
        logic                    gnt;
        logic                    rvalid;
        logic [INSTR_DATA_W-1:0] rdata;
        logic                    err;
    } core_instr_rsp_t;

    // I$ port, request side
    typedef struct packed {
        logic                    req;
        logic [INSTR_ADDR_W-1:0] addr;
    } core_cache_instr_req_t;

    // I$ port, response side (wide cache line data)
    typedef struct packed {
        logic                     gnt;
        logic                     rvalid;
        logic [ICACHE_DATA_W-1:0] rdata;
        logic                     err;
    } core_cache_instr_rsp_t;

    // Width of a lane index for a given cache/core ratio; never zero so
    // the offset FIFO always has a real storage field.
    function automatic int offs_width(input int ratio);
        if (ratio > 1) begin
            return $clog2(ratio);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/instr2cache_offs_fifo.sv
// Small circular FIFO holding the lane offset of every in-flight fetch.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, din_i : enqueue one offset
//   pop_i         : dequeue the head entry
//   dout_o        : head entry (valid while empty_o = 0)
//   full_o        : DEPTH entries stored
//   empty_o       : no entry stored
// Push and pop in the same cycle are accepted at any occupancy, including
// full, because the pop frees the slot the push fills.
module instr2cache_offs_fifo
    import magia_tile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Advance a pointer, wrapping at DEPTH rather than at a power of two
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Qualify push/pop so the storage can never over- or underflow
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
    end

    // Status flags derived from the occupancy counter
    always_comb begin
        full_o  = (count_r == CW'(DEPTH));
        empty_o = (count_r == {CW{1'b0}});
        dout_o  = mem_r[rd_ptr_r];
    end

    // Storage array
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr2cache_bridge.sv
// Bridge between the core instruction-fetch port and the tile I$.
// Requests and grants pass straight through, gated by a credit that limits
// the number of in-flight fetches to MAX_OUTSTANDING. The lane offset of each
// accepted fetch is queued; when the (in-order) I$ answers, that offset picks
// the core-width lane out of the wide response, which is then registered
// toward the core.
// Ports:
//   clk_i, rst_ni                        : clock, asynchronous active-low reset
//   instr_req_i/addr_i, instr_gnt_o      : core fetch request channel
//   instr_rvalid_o/rdata_o/err_o         : core fetch response (registered)
//   cache_req_o/addr_o, cache_gnt_i      : I$ request channel
//   cache_rvalid_i/rdata_i/err_i         : I$ response channel
//   outstanding_o                        : in-flight fetch count
//   proto_err_o                          : sticky, I$ answered with nothing in flight
module instr2cache_bridge
    import magia_tile_pkg::*;
#(
    parameter int ADDR_W          = INSTR_ADDR_W,
    parameter int CORE_DATA_W     = INSTR_DATA_W,
    parameter int CACHE_DATA_W    = ICACHE_DATA_W,
    parameter int MAX_OUTSTANDING = ICACHE_MAX_OUTSTANDING
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 instr_req_i,
    input  logic [ADDR_W-1:0]                    instr_addr_i,
    output logic                                 instr_gnt_o,
    output logic                                 instr_rvalid_o,
    output logic [CORE_DATA_W-1:0]               instr_rdata_o,
    output logic                                 instr_err_o,
    output logic                                 cache_req_o,
    output logic [ADDR_W-1:0]                    cache_addr_o,
    input  logic                                 cache_gnt_i,
    input  logic                                 cache_rvalid_i,
    input  logic [CACHE_DATA_W-1:0]              cache_rdata_i,
    input  logic                                 cache_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 proto_err_o
);

    localparam int RATIO  = CACHE_DATA_W / CORE_DATA_W;
    localparam int OFFS_W = offs_width(RATIO);
    localparam int LSB    = $clog2(CORE_DATA_W / 8);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]       cnt_r;
    logic                   credit_s;
    logic                   accept_s;
    logic                   resp_s;
    logic                   spurious_s;
    logic [OFFS_W-1:0]      push_offs_s;
    logic [OFFS_W-1:0]      head_offs_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   fifo_push_s;
    logic                   fifo_pop_s;
    logic [CORE_DATA_W-1:0] lane_s;
    logic                   rvalid_r;
    logic [CORE_DATA_W-1:0] rdata_r;
    logic                   err_r;
    logic                   proto_err_r;

    // Credit comes from the registered count only, so a response never
    // reopens the grant in the same cycle it arrives.
    always_comb begin
        credit_s     = (cnt_r < CNT_W'(MAX_OUTSTANDING));
        cache_req_o  = instr_req_i & credit_s;
        cache_addr_o = instr_addr_i;
        instr_gnt_o  = cache_gnt_i & credit_s;
        accept_s     = instr_req_i & instr_gnt_o;
        resp_s       = cache_rvalid_i & (cnt_r != {CNT_W{1'b0}});
        spurious_s   = cache_rvalid_i & (cnt_r == {CNT_W{1'b0}});
    end

    // With equal widths there is only one lane, so the offset is constant
    generate
        if (RATIO > 1) begin : g_offs
            assign push_offs_s = instr_addr_i[LSB +: OFFS_W];
        end else begin : g_no_offs
            assign push_offs_s = {OFFS_W{1'b0}};
        end
    endgenerate

    // Counter and FIFO occupancy track each other; the flags only add a
    // second line of defence against over/underflow.
    always_comb begin
        fifo_push_s = accept_s & (~fifo_full_s | resp_s);
        fifo_pop_s  = resp_s & ~fifo_empty_s;
    end

    instr2cache_offs_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (OFFS_W)
    ) u_offs_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push_s),
        .din_i   (push_offs_s),
        .pop_i   (fifo_pop_s),
        .dout_o  (head_offs_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Pick the core-width lane addressed by the oldest in-flight fetch
    always_comb begin
        lane_s = CORE_DATA_W'(cache_rdata_i >> (head_offs_s * CORE_DATA_W));
    end

    // In-flight counter: accept and response in one cycle cancel out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, resp_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Registered response toward the core; data/err hold between responses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {CORE_DATA_W{1'b0}};
            err_r    <= 1'b0;
        end else if (resp_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= lane_s;
            err_r    <= cache_err_i;
        end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= rdata_r;
            err_r    <= err_r;
        end
    end

    // Sticky flag for responses that match no outstanding fetch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            proto_err_r <= 1'b0;
        end else if (spurious_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    // Drive outputs from registers
    always_comb begin
        instr_rvalid_o = rvalid_r;
        instr_rdata_o  = rdata_r;
        instr_err_o    = err_r;
        outstanding_o  = cnt_r;
        proto_err_o    = proto_err_r;
    end

endmodule
